updown_count_sequencer: RTL and testbench

- Controller that sequences a gradual increment/decrement counter between programmable lower and upper limits.
- Counts up by a programmable step to the upper limit, dwells there, then counts down to the lower limit and dwells there.
- Repeats for a programmed number of round trips, or continuously.
- Sits above the gradual up/down counter datapath. Drives its count value and direction, and gives a start/abort/done control interface to upper-level logic.

---
 rtl/updown_count_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_updown_count_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_count_sequencer.sv
// updown_count_sequencer
// Sequences a gradual up/down counter between programmable limits. After a
// valid start the count climbs from lo to hi in steps of 'step', holds at hi
// for 1 + dwell cycles, descends back to lo, holds there, and repeats for
// 'trips' round trips (trips = 0 runs until aborted or reset).
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - request a new run (only looked at in IDLE)
//   abort    - stop the current run (only looked at outside IDLE)
//   lo_lim   - lower count limit
//   hi_lim   - upper count limit
//   step     - increment/decrement amount per cycle
//   dwell    - extra hold cycles at each limit
//   trips    - number of round trips, 0 = continuous
//   count    - registered counter value
//   dir      - 1 = counting up, 0 = counting down
//   busy     - high whenever the sequencer is not idle
//   done     - one-cycle pulse when the final trip completes
//   cfg_err  - one-cycle pulse when a start request is rejected
module updown_count_sequencer #(
  parameter int WIDTH   = 3,
  parameter int DWELL_W = 4,
  parameter int TRIP_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [WIDTH-1:0]   step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [TRIP_W-1:0]  trips,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [2:0] {IDLE, UP, DWELL_HI, DOWN, DWELL_LO} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   count_nxt;
  logic               dir_nxt, busy_nxt, done_nxt, cfg_err_nxt;
  logic [DWELL_W-1:0] timer, timer_nxt;
  logic [TRIP_W-1:0]  trip_cnt, trip_cnt_nxt;

  // Shadow copies of the configuration, captured on an accepted start so the
  // run is immune to input changes until the next start.
  logic [WIDTH-1:0]   lo_r, lo_r_nxt;
  logic [WIDTH-1:0]   hi_r, hi_r_nxt;
  logic [WIDTH-1:0]   step_r, step_r_nxt;
  logic [DWELL_W-1:0] dwell_r, dwell_r_nxt;
  logic [TRIP_W-1:0]  trips_r, trips_r_nxt;

  // Candidate next values for the counting states. The extra top bit catches
  // carry past the top of the range on the way up and borrow on the way down,
  // so both directions clamp to the limit instead of wrapping.
  logic [WIDTH:0]     up_sum, dn_diff;
  logic [WIDTH-1:0]   up_val, dn_val;
  logic [TRIP_W-1:0]  trip_inc;

  assign up_sum   = {1'b0, count} + {1'b0, step_r};
  assign up_val   = (up_sum > {1'b0, hi_r}) ? hi_r : up_sum[WIDTH-1:0];
  assign dn_diff  = {1'b0, count} - {1'b0, step_r};
  assign dn_val   = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < lo_r)) ? lo_r : dn_diff[WIDTH-1:0];
  assign trip_inc = trip_cnt + TRIP_W'(1);

  // State and output register bank. Every output is a flop so downstream
  // logic sees glitch-free values; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      dir      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      timer    <= '0;
      trip_cnt <= '0;
      lo_r     <= '0;
      hi_r     <= '0;
      step_r   <= '0;
      dwell_r  <= '0;
      trips_r  <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      dir      <= dir_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      cfg_err  <= cfg_err_nxt;
      timer    <= timer_nxt;
      trip_cnt <= trip_cnt_nxt;
      lo_r     <= lo_r_nxt;
      hi_r     <= hi_r_nxt;
      step_r   <= step_r_nxt;
      dwell_r  <= dwell_r_nxt;
      trips_r  <= trips_r_nxt;
    end
  end

  // Next-state and next-output logic. Everything holds by default and the
  // two status pulses default low, so each pulse lasts exactly one cycle.
  // Abort outranks every other transition once a run is in progress.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    dir_nxt      = dir;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    cfg_err_nxt  = 1'b0;
    timer_nxt    = timer;
    trip_cnt_nxt = trip_cnt;
    lo_r_nxt     = lo_r;
    hi_r_nxt     = hi_r;
    step_r_nxt   = step_r;
    dwell_r_nxt  = dwell_r;
    trips_r_nxt  = trips_r;

    if ((state != IDLE) && abort) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if ((lo_lim > hi_lim) || (step == '0)) begin
              cfg_err_nxt = 1'b1;
            end else begin
              lo_r_nxt     = lo_lim;
              hi_r_nxt     = hi_lim;
              step_r_nxt   = step;
              dwell_r_nxt  = dwell;
              trips_r_nxt  = trips;
              count_nxt    = lo_lim;
              dir_nxt      = 1'b1;
              busy_nxt     = 1'b1;
              trip_cnt_nxt = '0;
              state_nxt    = UP;
            end
          end
        end

        UP: begin
          count_nxt = up_val;
          if (up_val == hi_r) begin
            if (dwell_r == '0) begin
              state_nxt = DOWN;
              dir_nxt   = 1'b0;
            end else begin
              state_nxt = DWELL_HI;
              timer_nxt = dwell_r;
            end
          end
        end

        // The cycle that lands on the limit already counts as one hold
        // cycle, so leaving when the timer reads 1 gives 1 + dwell in total.
        DWELL_HI: begin
          timer_nxt = timer - DWELL_W'(1);
          if (timer == DWELL_W'(1)) begin
            state_nxt = DOWN;
            dir_nxt   = 1'b0;
          end
        end

        DOWN: begin
          count_nxt = dn_val;
          if (dn_val == lo_r) begin
            if ((trips_r != '0) && (trip_inc == trips_r)) begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              trip_cnt_nxt = trip_inc;
              if (dwell_r == '0) begin
                state_nxt = UP;
                dir_nxt   = 1'b1;
              end else begin
                state_nxt = DWELL_LO;
                timer_nxt = dwell_r;
              end
            end
          end
        end

        DWELL_LO: begin
          timer_nxt = timer - DWELL_W'(1);
          if (timer == DWELL_W'(1)) begin
            state_nxt = UP;
            dir_nxt   = 1'b1;
          end
        end

        default: begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// tb_updown_count_sequencer
// Self-checking bench for updown_count_sequencer. Expected behaviour comes
// from a trajectory model: for each run it lists, edge by edge, the count,
// direction, busy and done values implied by walking lo -> hi -> lo with
// clamping and dwell holds, and the bench compares the DUT against that list.
module tb_updown_count_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] lo_lim = '0;
  logic [2:0] hi_lim = '0;
  logic [2:0] step = '0;
  logic [3:0] dwell = '0;
  logic [3:0] trips = '0;
  logic [2:0] count;
  logic       dir, busy, done, cfg_err;

  int tests = 0;
  int fails = 0;
  int hold_count = 0;
  int hold_dir = 1;

  typedef struct {
    int count;
    int dir;
    int busy;
    int done;
  } exp_t;

  exp_t expq[$];

  updown_count_sequencer #(.WIDTH(3), .DWELL_W(4), .TRIP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .step(step), .dwell(dwell), .trips(trips),
    .count(count), .dir(dir), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and on a miss counts the failure and reports.
  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic push(input int c, input int d, input int b, input int dn);
    exp_t e;
    e.count = c;
    e.dir   = d;
    e.busy  = b;
    e.done  = dn;
    expq.push_back(e);
  endtask

  // Expected per-edge trajectory of a run, starting with the start edge.
  // ngen is how many round trips to list when trips = 0 (continuous).
  task automatic build_run(input int lo, input int hi, input int st, input int dw,
                           input int tr, input int ngen);
    int v;
    int n;
    expq.delete();
    push(lo, 1, 1, 0);
    n = (tr == 0) ? ngen : tr;
    for (int t = 0; t < n; t++) begin
      v = lo;
      do begin
        v = (v + st > hi) ? hi : v + st;
        if (v != hi) push(v, 1, 1, 0);
      end while (v != hi);
      for (int k = 0; k <= dw; k++) push(hi, (k == dw) ? 0 : 1, 1, 0);
      v = hi;
      do begin
        v = (v - st < lo) ? lo : v - st;
        if (v != lo) push(v, 0, 1, 0);
      end while (v != lo);
      if ((tr != 0) && (t == tr - 1)) begin
        push(lo, 0, 0, 1);
      end else begin
        for (int k = 0; k <= dw; k++) push(lo, (k == dw) ? 1 : 0, 1, 0);
      end
    end
    if (tr != 0) begin
      push(lo, 0, 0, 0);
      push(lo, 0, 0, 0);
    end
  endtask

  // Drive a configuration with start high; the next rising edge samples it.
  task automatic apply_stimulus(input int lo, input int hi, input int st, input int dw, input int tr);
    lo_lim = 3'(lo);
    hi_lim = 3'(hi);
    step   = 3'(st);
    dwell  = 4'(dw);
    trips  = 4'(tr);
    start  = 1'b1;
  endtask

  // Walk n entries of the expected trajectory, one per clock, checking on the
  // falling edge and scrambling the config inputs, which must be ignored.
  task automatic follow(input string tag, input int n);
    exp_t e;
    for (int i = 0; (i < n) && (expq.size() > 0); i++) begin
      @(negedge clk);
      start = 1'b0;
      e = expq.pop_front();
      check_output({tag, " count"}, 32'(count), e.count);
      check_output({tag, " dir"}, 32'(dir), e.dir);
      check_output({tag, " busy"}, 32'(busy), e.busy);
      check_output({tag, " done"}, 32'(done), e.done);
      check_output({tag, " cfg_err"}, 32'(cfg_err), 0);
      hold_count = e.count;
      hold_dir   = e.dir;
      lo_lim = 3'($urandom);
      hi_lim = 3'($urandom);
      step   = 3'($urandom);
      dwell  = 4'($urandom);
      trips  = 4'($urandom);
    end
  endtask

  task automatic cfg_reject(input string tag, input int lo, input int hi, input int st);
    apply_stimulus(lo, hi, st, 1, 1);
    @(negedge clk);
    start = 1'b0;
    check_output({tag, " cfg_err"}, 32'(cfg_err), 1);
    check_output({tag, " busy"}, 32'(busy), 0);
    check_output({tag, " count"}, 32'(count), hold_count);
    check_output({tag, " done"}, 32'(done), 0);
    @(negedge clk);
    check_output({tag, " cfg_err drop"}, 32'(cfg_err), 0);
    check_output({tag, " still idle"}, 32'(busy), 0);
  endtask

  task automatic do_abort(input string tag);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output({tag, " busy"}, 32'(busy), 0);
    check_output({tag, " count"}, 32'(count), hold_count);
    check_output({tag, " dir"}, 32'(dir), hold_dir);
    check_output({tag, " done"}, 32'(done), 0);
    expq.delete();
    @(negedge clk);
    check_output({tag, " hold"}, 32'(count), hold_count);
    check_output({tag, " idle"}, 32'(busy), 0);
  endtask

  initial begin
    int lo, hi, st, dw, tr, k;

    // Reset values, then an abort in IDLE which must have no effect.
    repeat (2) @(negedge clk);
    check_output("reset count", 32'(count), 0);
    check_output("reset dir", 32'(dir), 1);
    check_output("reset busy", 32'(busy), 0);
    check_output("reset done", 32'(done), 0);
    check_output("reset cfg_err", 32'(cfg_err), 0);
    rst = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("idle abort busy", 32'(busy), 0);
    check_output("idle abort count", 32'(count), 0);

    // Single trip with dwell: 1,3,5,6,6,6,4,2,1 then done.
    apply_stimulus(1, 6, 2, 2, 1);
    build_run(1, 6, 2, 2, 1, 0);
    follow("t1", 100);

    // Two trips, no dwell, clamp at 7 instead of wrapping.
    apply_stimulus(0, 7, 3, 0, 2);
    build_run(0, 7, 3, 0, 2, 0);
    follow("t2", 100);

    // Rejected configurations.
    cfg_reject("t3 lo>hi", 5, 2, 1);
    cfg_reject("t3 step0", 1, 6, 0);

    // Abort while descending at count 4, then restart reloads lo.
    apply_stimulus(1, 6, 2, 2, 1);
    build_run(1, 6, 2, 2, 1, 0);
    follow("t4", 7);
    check_output("t4 abort point", 32'(count), 4);
    do_abort("t4 abort");
    apply_stimulus(1, 6, 2, 2, 1);
    build_run(1, 6, 2, 2, 1, 0);
    follow("t4 restart", 100);

    // lo == hi: count constant, dir toggles, done after three trips.
    apply_stimulus(3, 3, 1, 0, 3);
    build_run(3, 3, 1, 0, 3, 0);
    follow("t6", 100);

    // Randomized runs, some aborted partway, plus random rejected starts.
    for (int r = 0; r < 12; r++) begin
      lo = $urandom_range(0, 7);
      hi = $urandom_range(lo, 7);
      st = $urandom_range(1, 7);
      dw = $urandom_range(0, 3);
      tr = $urandom_range(1, 3);
      apply_stimulus(lo, hi, st, dw, tr);
      build_run(lo, hi, st, dw, tr, 0);
      if (r % 3 == 2) begin
        k = $urandom_range(1, expq.size() - 3);
        follow("rand pre-abort", k);
        do_abort("rand abort");
      end else begin
        follow("rand run", 200);
      end
      if (r % 4 == 1) begin
        lo = $urandom_range(1, 7);
        hi = $urandom_range(0, lo - 1);
        cfg_reject("rand reject", lo, hi, $urandom_range(1, 7));
      end
    end

    // Continuous run; a start mid-run is ignored; async reset mid-cycle.
    apply_stimulus(2, 5, 1, 1, 0);
    build_run(2, 5, 1, 1, 0, 3);
    follow("t5", 12);
    start  = 1'b1;
    lo_lim = 3'd0;
    hi_lim = 3'd7;
    step   = 3'd3;
    follow("t5 ignore start", 8);
    #2 rst = 1'b0;
    #1;
    check_output("t5 async count", 32'(count), 0);
    check_output("t5 async dir", 32'(dir), 1);
    check_output("t5 async busy", 32'(busy), 0);
    check_output("t5 async done", 32'(done), 0);
    expq.delete();
    hold_count = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("t5 post-reset busy", 32'(busy), 0);
    check_output("t5 post-reset count", 32'(count), 0);

    // Recovery after reset with a fresh short run.
    apply_stimulus(0, 4, 2, 0, 1);
    build_run(0, 4, 2, 0, 1, 0);
    follow("recover", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
